// File: rtl/prog_mem_sync.sv
// Program memory with a power-up clear engine, write protection and range checking.
// Latency: read data and rvalid one cycle after re; writes commit at the request edge; err one cycle after a fault.
// Backpressure: none; ready is low while the clear engine runs and all requests are ignored.
//
// Ports:
//   mclk   - sole clock, rising edge
//   rst    - synchronous active-high reset; restarts the clear engine from address 0
//   we     - write request; waddr/wdata give the word address and data
//   re     - read request; raddr gives the word address
//   wp_en  - when set, writes below PROT_LIMIT are rejected
//   rdata  - registered read data, holds its value between reads
//   rvalid - one-cycle strobe qualifying rdata
//   ready  - high once every word holds INIT_VALUE and requests are accepted
//   err    - one-cycle pulse after a cycle containing a rejected write or out-of-range read
module prog_mem_sync #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [15:0]           PROT_LIMIT = 16'h0060,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [15:0]           waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [15:0]           raddr,
  input  logic                  wp_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  ready,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [ADDR_WIDTH-1:0]   ptr_d;
  logic                    ptr_last;

  logic                    init_we;
  logic                    run;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_oor;
  logic                    wr_prot;
  logic                    wr_req;
  logic                    wr_ok;
  logic                    wr_rej;
  logic                    rd_oor;
  logic                    rd_req;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign ptr_last = &ptr_q;

  // ---------------------------------------------------------------------------
  // Clear-engine FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: the last word is written in the same cycle that selects RUN,
  // so ready rises exactly DEPTH cycles after reset is released.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_last) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Outputs of the FSM
  always_comb begin
    init_we = 1'b0;
    run     = 1'b0;
    case (state_q)
      ST_INIT: init_we = 1'b1;
      ST_RUN:  run     = 1'b1;
      default: begin
        init_we = 1'b0;
        run     = 1'b0;
      end
    endcase
  end

  assign ready = run;

  // ---------------------------------------------------------------------------
  // Request decode. Any set bit above the word-address field is out of range.
  // Requests in the reset cycle are dropped so a read there never strobes.
  // ---------------------------------------------------------------------------
  assign wr_oor  = (waddr >> ADDR_WIDTH) != 16'd0;
  assign rd_oor  = (raddr >> ADDR_WIDTH) != 16'd0;
  assign wr_prot = wp_en && (waddr < PROT_LIMIT);

  assign wr_req  = run && we && !rst;
  assign rd_req  = run && re && !rst;
  assign wr_ok   = wr_req && !wr_oor && !wr_prot;
  assign wr_rej  = wr_req && (wr_oor || wr_prot);

  assign wr_idx  = waddr[ADDR_WIDTH-1:0];
  assign rd_idx  = raddr[ADDR_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Storage: the clear engine owns the write port during INIT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (!rst) begin
      if (init_we) begin
        mem[ptr_q] <= INIT_VALUE;
      end else if (wr_ok) begin
        mem[wr_idx] <= wdata;
      end
    end
  end

  // Write-first forwarding: an accepted write to the address being read this
  // cycle is returned in place of the stale array word. wr_ok already implies
  // an in-range write address, and rd_oor is checked first, so comparing the
  // truncated indices is sufficient.
  always_comb begin
    rd_word = mem[rd_idx];
    if (rd_oor) begin
      rd_word = '0;
    end else if (wr_ok && (wr_idx == rd_idx)) begin
      rd_word = wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered response. rdata only loads on a read so it holds between reads.
  // Both fault sources fold into one err pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_req;
      err    <= wr_rej || (rd_req && rd_oor);
      if (rd_req) begin
        rdata <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_sync.sv
// Scoreboard bench for prog_mem_sync: stimulus pushes expected read data and
// expected err cycles; a negedge monitor pops and compares whenever the DUT
// strobes rvalid or err.
module tb_prog_mem_sync;

  logic        mclk  = 1'b0;
  logic        rst   = 1'b1;
  logic        we    = 1'b0;
  logic [15:0] waddr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        re    = 1'b0;
  logic [15:0] raddr = 16'h0000;
  logic        wp_en = 1'b0;
  logic [15:0] rdata;
  logic        rvalid;
  logic        ready;
  logic        err;

  prog_mem_sync dut (
    .mclk   (mclk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr  (raddr),
    .wp_en  (wp_en),
    .rdata  (rdata),
    .rvalid (rvalid),
    .ready  (ready),
    .err    (err)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      err_q[$];
  int      total = 0;
  int      bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expectations only when the DUT presents an output.
  always @(negedge mclk) begin
    if (rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid: rdata %0h at cycle %0d, none expected", rdata, cyc);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rd_data", rdata, e.d);
      end
    end
    if (err === 1'b1) begin
      if (err_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_err: err at cycle %0d, none expected", cyc);
      end else begin
        check("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  // One request cycle followed by one idle cycle.
  task automatic access(input logic w, input logic [15:0] wa, input logic [15:0] wd,
                        input logic r, input logic [15:0] ra, input logic wp,
                        input logic [15:0] exp_d, input logic exp_err);
    rd_exp_t e;
    @(posedge mclk); #1;
    we = w; waddr = wa; wdata = wd; re = r; raddr = ra; wp_en = wp;
    if (r) begin
      e.cyc = cyc + 1;
      e.d   = exp_d;
      rd_q.push_back(e);
    end
    if (exp_err) err_q.push_back(cyc + 1);
    @(posedge mclk); #1;
    we = 1'b0; re = 1'b0; wp_en = 1'b0;
  endtask

  // Counts edges after reset release until ready; bounded.
  task automatic count_ready(input int limit, output int n);
    n = 0;
    while (ready !== 1'b1 && n < limit) begin
      @(posedge mclk); n++; #1;
    end
  endtask

  initial begin
    int n;

    // ---- reset state ----
    repeat (2) @(posedge mclk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 16'h0000);
    rst = 1'b0;

    // ---- clear latency, with stray requests during INIT ----
    n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      @(posedge mclk); n++; #1;
      we    = (n == 3);
      waddr = 16'h0020;
      wdata = 16'h1111;
      re    = (n == 3) || (n == 5);
      raddr = (n == 5) ? 16'h0300 : 16'h0020;
    end
    we = 1'b0; re = 1'b0;
    check("ready_latency", n, 256);

    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00FF, 1'b0, 16'h0000, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0);

    // ---- write protection ----
    access(1'b1, 16'h005F, 16'h1234, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1);
    access(1'b1, 16'h0060, 16'h5678, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h005F, 1'b0, 16'h0000, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0060, 1'b0, 16'h5678, 1'b0);

    // ---- write-first forwarding, then rdata hold while idle ----
    access(1'b1, 16'h0070, 16'hABCD, 1'b1, 16'h0070, 1'b0, 16'hABCD, 1'b0);
    @(posedge mclk); #1;
    check("idle_rvalid", rvalid, 0);
    check("rdata_hold", rdata, 16'hABCD);

    // ---- simultaneous out-of-range read and write: one err ----
    access(1'b1, 16'h0200, 16'h9999, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1);
    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // ---- rejected write with same-address read returns old data ----
    access(1'b1, 16'h0010, 16'h0011, 1'b1, 16'h0010, 1'b1, 16'h0000, 1'b1);
    access(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'hBEEF, 1'b0);

    // ---- independent read and write to different addresses ----
    access(1'b1, 16'h0080, 16'h2222, 1'b1, 16'h0070, 1'b0, 16'hABCD, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0080, 1'b0, 16'h2222, 1'b0);

    // ---- reset mid-RUN with a read in the reset cycle ----
    @(posedge mclk); #1;
    rst = 1'b1; re = 1'b1; raddr = 16'h0010;
    @(posedge mclk); #1;
    rst = 1'b0; re = 1'b0;
    check("rerun_ready", ready, 0);
    check("rerun_rdata", rdata, 16'h0000);
    check("rerun_rvalid", rvalid, 0);

    // ---- reset again mid-INIT: clear restarts from 0 ----
    count_ready(100, n);
    check("midinit_ready", ready, 0);
    @(posedge mclk); #1;
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    count_ready(1000, n);
    check("reclear_latency", n, 256);

    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
    access(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0060, 1'b0, 16'h0000, 1'b0);

    repeat (3) @(posedge mclk);
    #1;
    check("rd_q_drained", rd_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
